// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge SDRAM arbiter.
// Holds the address width, the arbiter FSM states and the requester ids.
package cart_pkg;

    localparam int ADDR_W = 25;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_IOCTL = 2'd0,
        REQ_SLOT0 = 2'd1,
        REQ_SLOT1 = 2'd2
    } req_id_e;

endpackage

// File: rtl/cart_rd_buf.sv
// One-entry read buffer for a cartridge slot.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   lookup_addr   - effective address the CPU currently wants
//   fill          - store fill_tag/fill_data and mark the entry valid
//   inval         - clear the valid bit (takes priority over fill)
//   hit           - entry valid and tag equals lookup_addr
//   data          - stored byte, 8'hFF after reset
module cart_rd_buf
    import cart_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [7:0]        fill_data,
    input  logic              inval,
    output logic              hit,
    output logic [7:0]        data
);

    logic              valid_r;
    logic [ADDR_W-1:0] tag_r;
    logic [7:0]        data_r;

    // Tag/data storage; a loader write landing in the fill cycle leaves the entry invalid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            tag_r   <= {ADDR_W{1'b0}};
            data_r  <= 8'hFF;
        end else begin
            if (fill) begin
                tag_r  <= fill_tag;
                data_r <= fill_data;
            end
            if (inval) begin
                valid_r <= 1'b0;
            end else if (fill) begin
                valid_r <= 1'b1;
            end
        end
    end

    assign hit  = valid_r & (tag_r == lookup_addr);
    assign data = data_r;

endmodule

// File: rtl/cart_sdram_arb.sv
// Arbitrates the single SDRAM controller port between the ROM loader write
// stream and the CPU read paths of two cartridge slots.
// Ports:
//   ioctl_*  - loader write strobe/address/data in, ioctl_wait back-pressure out
//   cpuN_*   - slot read request/address in, buffered data and wait out
//   mem_*    - command pulse/we/address/data to the controller, read data and ack back
// Loader writes have priority; slot misses alternate when both are pending.
module cart_sdram_arb
    import cart_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLOT1_BASE = 25'h100_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu0_rd,
    input  logic [ADDR_W-1:0] cpu0_addr,
    output logic [7:0]        cpu0_data,
    output logic              cpu0_wait,
    input  logic              cpu1_rd,
    input  logic [ADDR_W-1:0] cpu1_addr,
    output logic [7:0]        cpu1_data,
    output logic              cpu1_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack
);

    arb_state_e        state_r, state_nxt_s;
    req_id_e           gnt_r, sel_s;
    logic              wpend_r, last_r;
    logic [ADDR_W-1:0] wr_addr_r, sel_addr_s, mem_addr_r, eff0_s, eff1_s;
    logic [7:0]        wr_data_r, sel_din_s, mem_din_r;
    logic              mem_req_r, mem_we_r, sel_we_s;
    logic              go_s, done_s, capture_s;
    logic              hit0_s, hit1_s, miss0_s, miss1_s, fill0_s, fill1_s;

    // Slot 1 lives at a fixed offset; the 25-bit sum wraps naturally.
    assign eff0_s    = cpu0_addr;
    assign eff1_s    = cpu1_addr + SLOT1_BASE;
    // Strobes arriving while a write is still pending are dropped.
    assign capture_s = ioctl_wr & ~wpend_r;
    assign miss0_s   = cpu0_rd & ~hit0_s;
    assign miss1_s   = cpu1_rd & ~hit1_s;
    assign fill0_s   = done_s & (gnt_r == REQ_SLOT0);
    assign fill1_s   = done_s & (gnt_r == REQ_SLOT1);

    cart_rd_buf u_buf0 (
        .clk(clk), .reset_n(reset_n), .lookup_addr(eff0_s),
        .fill(fill0_s), .fill_tag(mem_addr_r), .fill_data(mem_dout),
        .inval(capture_s), .hit(hit0_s), .data(cpu0_data)
    );

    cart_rd_buf u_buf1 (
        .clk(clk), .reset_n(reset_n), .lookup_addr(eff1_s),
        .fill(fill1_s), .fill_tag(mem_addr_r), .fill_data(mem_dout),
        .inval(capture_s), .hit(hit1_s), .data(cpu1_data)
    );

    // Next-state and requester selection; last_r=1 means slot 1 was served last.
    always_comb begin
        state_nxt_s = state_r;
        go_s        = 1'b0;
        done_s      = 1'b0;
        sel_s       = REQ_IOCTL;
        sel_addr_s  = wr_addr_r;
        sel_we_s    = 1'b1;
        sel_din_s   = wr_data_r;
        case (state_r)
            ARB_IDLE: begin
                if (wpend_r) begin
                    go_s = 1'b1;
                end else if (miss0_s && (!miss1_s || last_r)) begin
                    go_s       = 1'b1;
                    sel_s      = REQ_SLOT0;
                    sel_addr_s = eff0_s;
                    sel_we_s   = 1'b0;
                    sel_din_s  = 8'h00;
                end else if (miss1_s) begin
                    go_s       = 1'b1;
                    sel_s      = REQ_SLOT1;
                    sel_addr_s = eff1_s;
                    sel_we_s   = 1'b0;
                    sel_din_s  = 8'h00;
                end else begin
                    go_s = 1'b0;
                end
                if (go_s) begin
                    state_nxt_s = ARB_ISSUE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_nxt_s = ARB_WAIT;
            ARB_WAIT: begin
                if (mem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_WAIT;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // State, command registers, pending loader write and fairness bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ARB_IDLE;
            gnt_r      <= REQ_IOCTL;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= 8'h00;
            wpend_r    <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= 8'h00;
            last_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            mem_req_r <= go_s;
            if (go_s) begin
                gnt_r      <= sel_s;
                mem_we_r   <= sel_we_s;
                mem_addr_r <= sel_addr_s;
                mem_din_r  <= sel_din_s;
            end
            if (capture_s) begin
                wpend_r   <= 1'b1;
                wr_addr_r <= ioctl_addr;
                wr_data_r <= ioctl_dout;
            end else if (done_s && gnt_r == REQ_IOCTL) begin
                wpend_r <= 1'b0;
            end
            if (fill0_s) begin
                last_r <= 1'b0;
            end else if (fill1_s) begin
                last_r <= 1'b1;
            end
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_din    = mem_din_r;
    assign ioctl_wait = wpend_r;
    assign cpu0_wait  = miss0_s;
    assign cpu1_wait  = miss1_s;

endmodule

// File: tb/tb_cart_sdram_arb.sv
// Directed bench for cart_sdram_arb with a fixed-latency SDRAM controller model.
module tb_cart_sdram_arb;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        cpu0_rd, cpu1_rd;
    logic [24:0] cpu0_addr, cpu1_addr;
    logic [7:0]  cpu0_data, cpu1_data;
    logic        cpu0_wait, cpu1_wait;
    logic        mem_req, mem_we, mem_ack;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;

    int checks = 0;
    int failures = 0;

    int          req_cnt = 0;
    int          wr_cnt = 0;
    logic [24:0] last_addr = 25'h0;
    logic        last_we = 1'b0;
    logic [7:0]  last_din = 8'h00;
    logic [7:0]  smem [logic [24:0]];

    always #5 clk = ~clk;

    cart_sdram_arb dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .cpu0_rd(cpu0_rd), .cpu0_addr(cpu0_addr), .cpu0_data(cpu0_data), .cpu0_wait(cpu0_wait),
        .cpu1_rd(cpu1_rd), .cpu1_addr(cpu1_addr), .cpu1_data(cpu1_data), .cpu1_wait(cpu1_wait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] rdata(input logic [24:0] a);
        if (smem.exists(a)) return smem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    // Controller model: ack exactly LAT cycles after the command cycle.
    int          pend_cnt = 0;
    logic [24:0] pend_addr;
    logic        pend_we;
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_ack  = 1'b1;
                    mem_dout = pend_we ? 8'h00 : rdata(pend_addr);
                end
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                last_addr = mem_addr;
                last_we   = mem_we;
                last_din  = mem_din;
                if (mem_we) begin
                    wr_cnt++;
                    smem[mem_addr] = mem_din;
                end
                pend_addr = mem_addr;
                pend_we   = mem_we;
                pend_cnt  = LAT;
            end
        end
    end

    task automatic wait_req(input int prev, input string tag);
        int n = 0;
        while (req_cnt == prev && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(req_cnt != prev), 32'd1);
    endtask

    task automatic wait_low(input int slot, input string tag);
        int n = 0;
        while (((slot == 0) ? cpu0_wait : cpu1_wait) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'((slot == 0) ? cpu0_wait : cpu1_wait), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        int cnt;
        logic rose;
        logic g;
        reset_n = 1'b0;
        ioctl_wr = 1'b0; ioctl_addr = 25'h0; ioctl_dout = 8'h00;
        cpu0_rd = 1'b0; cpu0_addr = 25'h0;
        cpu1_rd = 1'b0; cpu1_addr = 25'h0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(mem_din), 32'd0);
        chk("rst_iowait", 32'(ioctl_wait), 32'd0);
        chk("rst_d0", 32'(cpu0_data), 32'hFF);
        chk("rst_d1", 32'(cpu1_data), 32'hFF);

        // Slot 0 miss: wait high for 1 + 1 + LAT cycles.
        prev = req_cnt;
        cpu0_addr = 25'h0_4000; cpu0_rd = 1'b1;
        #1;
        cnt = 0;
        while (cpu0_wait === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("miss_wait_cycles", 32'(cnt), 32'd5);
        chk("miss_req_count", 32'(req_cnt - prev), 32'd1);
        chk("miss_addr", 32'(last_addr), 32'h0_4000);
        chk("miss_we", 32'(last_we), 32'd0);
        chk("miss_data", 32'(cpu0_data), 32'hA5);

        // Repeat read of the same byte: pure hit.
        cpu0_rd = 1'b0;
        tick();
        prev = req_cnt;
        cpu0_rd = 1'b1;
        #1;
        rose = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rose |= cpu0_wait;
            tick();
        end
        chk("hit_no_wait", 32'(rose), 32'd0);
        chk("hit_no_req", 32'(req_cnt - prev), 32'd0);
        chk("hit_data", 32'(cpu0_data), 32'hA5);
        cpu0_rd = 1'b0;

        // Slot 1 offset and wrap-around.
        prev = req_cnt;
        cpu1_addr = 25'h0_0010; cpu1_rd = 1'b1;
        wait_req(prev, "s1_req_seen");
        chk("s1_addr", 32'(last_addr), 32'h100_0010);
        wait_low(1, "s1_wait_low");
        chk("s1_data", 32'(cpu1_data), 32'hB5);
        prev = req_cnt;
        cpu1_addr = 25'h1FF_0005;
        wait_req(prev, "wrap_req_seen");
        chk("wrap_addr", 32'(last_addr), 32'h0FF_0005);
        wait_low(1, "wrap_wait_low");
        chk("wrap_data", 32'(cpu1_data), 32'hA0);
        cpu1_rd = 1'b0;
        tick();

        // Both slots keep missing: grants alternate 0,1,0,1.
        cpu0_addr = 25'h0_0100; cpu1_addr = 25'h0_0200;
        cpu0_rd = 1'b1; cpu1_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prev = req_cnt;
            wait_req(prev, "rr_req_seen");
            g = last_addr[24];
            chk($sformatf("rr_grant%0d", i), 32'(g), 32'(i % 2));
            wait_low(g ? 1 : 0, "rr_wait_low");
            if (i == 3) begin
                cpu0_rd = 1'b0; cpu1_rd = 1'b0;
            end else if (g) begin
                cpu1_addr = cpu1_addr + 25'd1;
            end else begin
                cpu0_addr = cpu0_addr + 25'd1;
            end
        end
        repeat (8) tick();

        // Loader write captured in the ack cycle of a slot 0 read.
        prev = req_cnt;
        cpu0_addr = 25'h0_0300; cpu0_rd = 1'b1;
        wait_req(prev, "ld_rd_req");
        tick(); tick(); tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'h0_0300; ioctl_dout = 8'h3C;
        tick();
        ioctl_wr = 1'b0;
        #1;
        chk("ld_iowait_hi", 32'(ioctl_wait), 32'd1);
        chk("ld_inval", 32'(cpu0_wait), 32'd1);
        prev = req_cnt;
        wait_req(prev, "ld_wr_req");
        chk("ld_wr_we", 32'(last_we), 32'd1);
        chk("ld_wr_addr", 32'(last_addr), 32'h0_0300);
        chk("ld_wr_din", 32'(last_din), 32'h3C);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0_0777; ioctl_dout = 8'h11;
        tick();
        ioctl_wr = 1'b0;
        chk("ld_iowait_held", 32'(ioctl_wait), 32'd1);
        cnt = 0;
        while (ioctl_wait && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("ld_iowait_low", 32'(ioctl_wait), 32'd0);
        wait_low(0, "ld_reread_low");
        chk("ld_reread_addr", 32'(last_addr), 32'h0_0300);
        chk("ld_reread_we", 32'(last_we), 32'd0);
        chk("ld_reread_data", 32'(cpu0_data), 32'h3C);
        repeat (6) tick();
        chk("ld_one_write", 32'(wr_cnt), 32'd1);
        cpu0_rd = 1'b0;
        tick();

        // Reset during WAIT; the late ack must be ignored.
        prev = req_cnt;
        cpu0_addr = 25'h0_0500; cpu0_rd = 1'b1;
        wait_req(prev, "rstw_req");
        tick();
        reset_n = 1'b0; cpu0_rd = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rstw_req_low", 32'(mem_req), 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_d0", 32'(cpu0_data), 32'hFF);
        tick();
        tick();
        cpu0_rd = 1'b1;
        #1;
        chk("rstw_no_fill_d0", 32'(cpu0_data), 32'hFF);
        chk("rstw_no_fill_wait", 32'(cpu0_wait), 32'd1);
        chk("rstw_iowait", 32'(ioctl_wait), 32'd0);
        chk("rstw_we", 32'(mem_we), 32'd0);
        wait_low(0, "rstw_refill_low");
        chk("rstw_refill_data", 32'(cpu0_data), 32'hA5);
        cpu0_rd = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
